// File: rtl/mux4_sel_arbiter_pkg.sv
// Shared constants and state type for the 4:1 mux select arbiter.
package mux4_sel_arbiter_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux4_sel_arbiter_rr_pick4.sv
// Round-robin picker: first set request scanning last+1, last+2, ... (mod 4).
module rr_pick4
  import mux4_sel_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  logic [SEL_W-1:0] idx;

  // Scan farthest offset first so the nearest requester after last wins.
  always_comb begin
    pick = last;
    any  = 1'b0;
    idx  = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux with bounded-burst grants.
module mux4_sel_arbiter
  import mux4_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
  output logic              s1,
  output logic              s0,
  output logic [NUM_CH-1:0] gnt,
  output logic              out_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  last_q;
  logic [NUM_CH-1:0] gnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [SEL_W-1:0]  pick_w;
  logic              any_w;
  logic              beat_w;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_w),
    .any  (any_w)
  );

  // Valid only while a grant is held and the granted channel still has data.
  assign out_valid = (state_q == ST_BUSY) & req[sel_q];
  assign beat_w    = out_valid & out_ready;
  assign cnt_d     = cnt_q + 1'b1;

  // Grant FSM: selects, grant vector, burst counter and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_w) begin
            state_q <= ST_BUSY;
            sel_q   <= pick_w;
            last_q  <= pick_w;
            gnt_q   <= NUM_CH'(1) << pick_w;
            cnt_q   <= '0;
          end else begin
            gnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (!req[sel_q]) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
          end else if (beat_w) begin
            if (cnt_q == LAST_BEAT) begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign gnt  = gnt_q;
  assign busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
module tb_mux4_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rdy = 1'b0;

  logic       s1_0, s0_0, ov_0, busy_0;
  logic [3:0] gnt_0;
  logic       s1_1, s0_1, ov_1, busy_1;
  logic [3:0] gnt_1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_sel_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
    .s1(s1_0), .s0(s0_0), .gnt(gnt_0), .out_valid(ov_0), .busy(busy_0)
  );

  mux4_sel_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
    .s1(s1_1), .s0(s0_1), .gnt(gnt_1), .out_valid(ov_1), .busy(busy_1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: granted channel (-1 = none), beats taken, pointer.
  int  m_g[2];
  int  m_cnt[2];
  int  m_last[2];
  int  m_sel[2];
  int  m_mb[2] = '{4, 1};
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_g[m] = -1; m_sel[m] = 0; m_cnt[m] = 0; m_last[m] = 3;
      end else if (m_g[m] < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_g[m] < 0 && req[(m_last[m] + k) % 4]) begin
            m_g[m] = (m_last[m] + k) % 4;
          end
        end
        if (m_g[m] >= 0) begin
          m_sel[m] = m_g[m]; m_last[m] = m_g[m]; m_cnt[m] = 0;
        end
      end else if (!req[m_g[m]]) begin
        m_g[m] = -1;
      end else if (rdy) begin
        if (m_cnt[m] + 1 == m_mb[m]) m_g[m] = -1;
        else m_cnt[m] = m_cnt[m] + 1;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic cmp_dut(input int m, input logic s1, input logic s0,
                         input logic [3:0] g, input logic ov, input logic b);
    int eb, eg, eov;
    eb  = (m_g[m] >= 0) ? 1 : 0;
    eg  = eb ? (1 << m_g[m]) : 0;
    eov = (eb != 0 && req[m_sel[m]]) ? 1 : 0;
    chk($sformatf("model_busy%0d", m), int'(b), eb);
    chk($sformatf("model_gnt%0d", m), int'(g), eg);
    chk($sformatf("model_sel%0d", m), int'({s1, s0}), m_sel[m]);
    chk($sformatf("model_valid%0d", m), int'(ov), eov);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_dut(0, s1_0, s0_0, gnt_0, ov_0, busy_0);
      cmp_dut(1, s1_1, s0_1, gnt_1, ov_1, busy_1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt0(input logic [3:0] want, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt_0 !== want && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (gnt_0 !== want) chk({nm, "_timeout"}, int'(gnt_0), int'(want));
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", int'(gnt_0), 0);
    chk("rst_busy", int'(busy_0), 0);
    chk("rst_sel", int'({s1_0, s0_0}), 0);
    chk("rst_valid", int'(ov_0), 0);

    // 1: reset mid-burst on channel 0
    do_reset();
    req = 4'b0001; rdy = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_gnt", int'(gnt_0), 0);
    chk("t1_busy", int'(busy_0), 0);
    chk("t1_sel", int'({s1_0, s0_0}), 0);
    chk("t1_valid", int'(ov_0), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_regrant", int'(gnt_0), 1);

    // 2: MAX_BURST=1, all requesting: 0,1,2,3,0 with bubbles
    do_reset();
    req = 4'b1111; rdy = 1'b1;
    @(negedge clk);
    chk("t2_idle0", int'(gnt_1), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", k), int'(gnt_1), 1 << (k % 4));
      chk($sformatf("t2_sel%0d", k), int'({s1_1, s0_1}), k % 4);
      @(negedge clk);
      chk($sformatf("t2_bubble%0d", k), int'(gnt_1), 0);
    end

    // 3: channel 2 alone, 4-beat burst then one bubble then re-grant
    do_reset();
    req = 4'b0100; rdy = 1'b1;
    wait_gnt0(4'b0100, "t3_gnt");
    n = 0;
    while (gnt_0 === 4'b0100 && n < 20) begin
      if (ov_0) n++;
      @(negedge clk);
    end
    chk("t3_beats", n, 4);
    chk("t3_bubble", int'(gnt_0), 0);
    @(negedge clk);
    chk("t3_regrant", int'(gnt_0), 4);

    // 4: channel 1 stalled 5 cycles, then burst completes
    do_reset();
    req = 4'b0010; rdy = 1'b0;
    wait_gnt0(4'b0010, "t4_gnt");
    for (int k = 0; k < 5; k++) begin
      chk("t4_sel", int'({s1_0, s0_0}), 1);
      chk("t4_valid", int'(ov_0), 1);
      @(negedge clk);
    end
    rdy = 1'b1;
    n = 0;
    while (gnt_0 === 4'b0010 && n < 20) begin
      if (ov_0 && rdy) n++;
      @(negedge clk);
    end
    chk("t4_beats", n, 4);

    // 6: no requests for 10 cycles, selects hold at 01
    req = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_gnt", int'(gnt_0), 0);
      chk("t6_busy", int'(busy_0), 0);
      chk("t6_valid", int'(ov_0), 0);
      chk("t6_sel", int'({s1_0, s0_0}), 1);
    end

    // 5: channel 3 withdraws after one beat; next grant goes to channel 0
    do_reset();
    req = 4'b1000; rdy = 1'b1;
    wait_gnt0(4'b1000, "t5_gnt");
    tick();
    req = 4'b0011;
    @(negedge clk);
    chk("t5_busy", int'(busy_0), 1);
    chk("t5_novalid", int'(ov_0), 0);
    @(negedge clk);
    chk("t5_idle", int'(gnt_0), 0);
    @(negedge clk);
    chk("t5_next", int'(gnt_0), 1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
